color_centroid_tracker: RTL and testbench

//  Downstream stage of the window pixel sampler; takes its sampled RGB stream for one frame.

---
 rtl/tracker_pkg.sv | 28 ++
 rtl/seq_divider.sv | 73 +++++++
 rtl/color_centroid_tracker.sv | 146 ++++++++++++++
 tb/tb_color_centroid_tracker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared constants, state encoding and the colour-box test for the centroid tracker.
package tracker_pkg;

  localparam int IMG_W     = 128;
  localparam int IMG_H     = 128;
  localparam int MIN_COUNT = 64;
  localparam int CNT_W     = 15;
  localparam int SUM_W     = 22;
  localparam int COL_W     = 10;
  localparam int X_W       = $clog2(IMG_W);
  // y must be able to reach IMG_H so the end-of-frame guard can see it.
  localparam int Y_W       = $clog2(IMG_H + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DIVX,
    S_DIVY,
    S_DONE
  } state_t;

  function automatic logic in_box(input logic [COL_W-1:0] v,
                                  input logic [COL_W-1:0] lo,
                                  input logic [COL_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, NUM_W cycles per divide.
module seq_divider #(
  parameter int NUM_W  = 22,
  parameter int DEN_W  = 15,
  parameter int QUOT_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [NUM_W-1:0]  i_num,
  input  logic [DEN_W-1:0]  i_den,
  output logic [QUOT_W-1:0] o_quot,
  output logic              o_done
);

  localparam int LEFT_W = $clog2(NUM_W);

  logic [DEN_W-1:0]  rem;
  logic [DEN_W-1:0]  den;
  logic [NUM_W-1:0]  quot;
  logic [LEFT_W-1:0] left;
  logic              busy;

  logic [DEN_W-1:0]  src_rem;
  logic [DEN_W-1:0]  src_den;
  logic [NUM_W-1:0]  src_quot;
  logic [DEN_W:0]    shifted;
  logic              take;
  logic [DEN_W-1:0]  next_rem;
  logic [NUM_W-1:0]  next_quot;

  // The first iteration is folded into the load cycle so a divide takes exactly NUM_W cycles.
  always_comb begin
    src_rem   = i_start ? '0    : rem;
    src_den   = i_start ? i_den : den;
    src_quot  = i_start ? i_num : quot;
    shifted   = {src_rem, src_quot[NUM_W-1]};
    take      = (shifted >= {1'b0, src_den});
    next_rem  = DEN_W'(take ? (shifted - {1'b0, src_den}) : shifted);
    next_quot = {src_quot[NUM_W-2:0], take};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rem    <= '0;
      den    <= '0;
      quot   <= '0;
      left   <= '0;
      busy   <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start) begin
        rem  <= next_rem;
        den  <= i_den;
        quot <= next_quot;
        left <= LEFT_W'(NUM_W - 1);
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= next_rem;
        quot <= next_quot;
        left <= left - LEFT_W'(1);
        if (left == LEFT_W'(1)) begin
          busy   <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
  end

  assign o_quot = quot[QUOT_W-1:0];

endmodule

// File: rtl/color_centroid_tracker.sv
// Accumulates coordinates of pixels inside an RGB box over one frame, then divides out the centroid.
module color_centroid_tracker
  import tracker_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [COL_W-1:0] i_Red,
  input  logic [COL_W-1:0] i_Green,
  input  logic [COL_W-1:0] i_Blue,
  input  logic             i_finish,
  input  logic [COL_W-1:0] i_r_min,
  input  logic [COL_W-1:0] i_r_max,
  input  logic [COL_W-1:0] i_g_min,
  input  logic [COL_W-1:0] i_g_max,
  input  logic [COL_W-1:0] i_b_min,
  input  logic [COL_W-1:0] i_b_max,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_found,
  output logic [X_W-1:0]   o_x,
  output logic [X_W-1:0]   o_y,
  output logic [CNT_W-1:0] o_count
);

  state_t state, next_state;

  logic [X_W-1:0]   x_pos;
  logic [Y_W-1:0]   y_pos;
  logic [SUM_W-1:0] sum_x;
  logic [SUM_W-1:0] sum_y;
  logic [CNT_W-1:0] count;
  logic [X_W-1:0]   x_quot;
  logic             kick;

  logic             enough;
  logic             pixel_hit;
  logic             clear_frame;
  logic             pix_take;
  logic             div_start;
  logic             div_done;
  logic [SUM_W-1:0] div_num;
  logic [X_W-1:0]   div_quot;

  assign enough    = (count >= CNT_W'(MIN_COUNT));
  assign pixel_hit = in_box(i_Red,   i_r_min, i_r_max) &&
                     in_box(i_Green, i_g_min, i_g_max) &&
                     in_box(i_Blue,  i_b_min, i_b_max);

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    unique case (state)
      S_IDLE:  if (i_start) next_state = S_ACCUM;
      S_ACCUM: if (i_finish) next_state = S_DIVX;
      S_DIVX: begin
        if (kick && !enough) next_state = S_DONE;
        else if (div_done)   next_state = S_DIVY;
      end
      S_DIVY:  if (div_done) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The y divide is launched in the same cycle the x quotient comes out, so the two run back to back.
  always_comb begin
    o_busy      = (state == S_ACCUM) || (state == S_DIVX) || (state == S_DIVY);
    clear_frame = i_start && ((state == S_IDLE) || ((state == S_ACCUM) && !i_finish));
    pix_take    = (state == S_ACCUM) && i_valid && !clear_frame && (y_pos < Y_W'(IMG_H));
    div_start   = (state == S_DIVX) && ((kick && enough) || div_done);
    div_num     = kick ? sum_x : sum_y;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_pos   <= '0;
      y_pos   <= '0;
      sum_x   <= '0;
      sum_y   <= '0;
      count   <= '0;
      x_quot  <= '0;
      kick    <= 1'b0;
      o_valid <= 1'b0;
      o_found <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_count <= '0;
    end else begin
      kick <= (state == S_ACCUM) && i_finish;
      if (clear_frame) begin
        x_pos <= '0;
        y_pos <= '0;
        sum_x <= '0;
        sum_y <= '0;
        count <= '0;
      end else if (pix_take) begin
        if (x_pos == X_W'(IMG_W - 1)) begin
          x_pos <= '0;
          y_pos <= y_pos + Y_W'(1);
        end else begin
          x_pos <= x_pos + X_W'(1);
        end
        if (pixel_hit) begin
          sum_x <= sum_x + SUM_W'(x_pos);
          sum_y <= sum_y + SUM_W'(y_pos);
          count <= count + CNT_W'(1);
        end
      end

      if ((state == S_DIVX) && div_done) x_quot <= div_quot;

      o_valid <= (next_state == S_DONE);
      if (next_state == S_DONE) begin
        o_count <= count;
        o_found <= enough;
        if (enough) begin
          o_x <= x_quot;
          o_y <= div_quot;
        end
      end
    end
  end

  seq_divider #(
    .NUM_W  (SUM_W),
    .DEN_W  (CNT_W),
    .QUOT_W (X_W)
  ) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (div_start),
    .i_num   (div_num),
    .i_den   (count),
    .o_quot  (div_quot),
    .o_done  (div_done)
  );

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Self-checking bench: table of frames with known centroids, hand sequences, randomized frames vs model.
module tb_color_centroid_tracker;
  import tracker_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start = 1'b0, i_valid = 1'b0, i_finish = 1'b0;
  logic [COL_W-1:0] i_Red = '0, i_Green = '0, i_Blue = '0;
  logic [COL_W-1:0] r_min = '0, r_max = '0, g_min = '0, g_max = '0, b_min = '0, b_max = '0;
  logic             o_busy, o_valid, o_found;
  logic [X_W-1:0]   o_x, o_y;
  logic [CNT_W-1:0] o_count;

  always #5 clk = ~clk;

  color_centroid_tracker dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_Red(i_Red), .i_Green(i_Green), .i_Blue(i_Blue), .i_finish(i_finish),
    .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
    .i_b_min(b_min), .i_b_max(b_max),
    .o_busy(o_busy), .o_valid(o_valid), .o_found(o_found),
    .o_x(o_x), .o_y(o_y), .o_count(o_count)
  );

  typedef struct {
    string name;
    int    rmin, rmax, gmin, gmax, bmin, bmax;
    int    bx, by, bw, bh;
    int    npix;
    int    e_cnt;
    bit    e_found;
    int    e_x, e_y, e_lat;
  } vec_t;

  int     n_checks = 0;
  int     n_errors = 0;
  longint m_sx, m_sy;
  int     m_cnt, m_idx;
  int     exp_x = 0, exp_y = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int rl, input int rh, input int gl, input int gh, input int bl, input int bh);
    r_min = 10'(rl); r_max = 10'(rh);
    g_min = 10'(gl); g_max = 10'(gh);
    b_min = 10'(bl); b_max = 10'(bh);
  endtask

  function automatic bit in_rect(input int k, input int bx, input int by, input int bw, input int bh);
    int x, y;
    x = k % IMG_W;
    y = k / IMG_W;
    return (x >= bx) && (x < bx + bw) && (y >= by) && (y < by + bh);
  endfunction

  task automatic begin_frame();
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    m_idx = 0; m_sx = 0; m_sy = 0; m_cnt = 0;
  endtask

  // Model: the k-th accepted pulse sits at (k mod IMG_W, k div IMG_W); pulses past the frame are dropped.
  task automatic push(input int r, input int g, input int b, input bit fin);
    i_valid = 1'b1; i_finish = fin;
    i_Red = 10'(r); i_Green = 10'(g); i_Blue = 10'(b);
    if (m_idx < IMG_W * IMG_H) begin
      if (r >= int'(r_min) && r <= int'(r_max) && g >= int'(g_min) && g <= int'(g_max) &&
          b >= int'(b_min) && b <= int'(b_max)) begin
        m_sx += m_idx % IMG_W;
        m_sy += m_idx / IMG_W;
        m_cnt++;
      end
      m_idx++;
    end
    cyc();
    i_valid = 1'b0; i_finish = 1'b0;
  endtask

  task automatic push_rect(input int k, input int bx, input int by, input int bw, input int bh, input bit fin);
    if (in_rect(k, bx, by, bw, bh)) push(900, 50, 50, fin);
    else                            push(100, 500, 500, fin);
  endtask

  // Called in the cycle after i_finish was sampled; counts cycles until o_valid.
  task automatic await_result(input string name, input int e_cnt, input bit e_found,
                              input int e_x, input int e_y, input int e_lat, input bit noisy);
    int lat;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
      i_start  = noisy && (k + 1 == 10);
      i_valid  = noisy && ($urandom_range(0, 1) == 1);
      i_finish = noisy && ($urandom_range(0, 3) == 0);
      i_Red    = 10'($urandom); i_Green = 10'($urandom); i_Blue = 10'($urandom);
    end
    i_start = 1'b0; i_valid = 1'b0; i_finish = 1'b0;
    check({name, ":latency"}, lat, e_lat);
    check({name, ":count"}, o_count, e_cnt);
    check({name, ":found"}, o_found, e_found);
    check({name, ":x"}, o_x, e_x);
    check({name, ":y"}, o_y, e_y);
    check({name, ":busy_in_done"}, o_busy, 0);
    @(negedge clk);
    check({name, ":valid_pulse"}, o_valid, 0);
    check({name, ":idle_busy"}, o_busy, 0);
    cyc();
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{"no_hits",      800, 1023, 0, 100, 0, 100,  0,  0,  0,  0, 16384,   0, 1'b0,   0,  0,  2};
    tbl[1] = '{"blob",         800, 1023, 0, 100, 0, 100, 40, 60, 10, 10,  8960, 100, 1'b1,  44, 64, 46};
    tbl[2] = '{"below_min",    800, 1023, 0, 100, 0, 100, 10,  5,  7,  7,  1536,  49, 1'b0,  44, 64,  2};
    tbl[3] = '{"inverted",    1000,  800, 0, 100, 0, 100,  0,  0, 16, 16,  2048,   0, 1'b0,  44, 64,  2};
    tbl[4] = '{"corner_fin",   800, 1023, 0, 100, 0, 100,120,  0,  8, 10,  1280,  80, 1'b1, 123,  4, 46};
    tbl[5] = '{"exact_bounds", 900,  900,50,  50,50,  50,  0,  0,  8,  8,  1024,  64, 1'b1,   3,  3, 46};

    // Reset state
    repeat (3) cyc();
    @(negedge clk);
    check("reset:valid", o_valid, 0);
    check("reset:found", o_found, 0);
    check("reset:x", o_x, 0);
    check("reset:y", o_y, 0);
    check("reset:count", o_count, 0);
    check("reset:busy", o_busy, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Table frames; the last pixel always arrives together with i_finish
    foreach (tbl[i]) begin
      set_box(tbl[i].rmin, tbl[i].rmax, tbl[i].gmin, tbl[i].gmax, tbl[i].bmin, tbl[i].bmax);
      begin_frame();
      for (int k = 0; k < tbl[i].npix; k++)
        push_rect(k, tbl[i].bx, tbl[i].by, tbl[i].bw, tbl[i].bh, k == tbl[i].npix - 1);
      await_result(tbl[i].name, tbl[i].e_cnt, tbl[i].e_found, tbl[i].e_x, tbl[i].e_y, tbl[i].e_lat, 1'b0);
      exp_x = tbl[i].e_x; exp_y = tbl[i].e_y;
    end

    // Restart mid-frame: the blob seen before the second i_start must not count
    set_box(800, 1023, 0, 100, 0, 100);
    begin_frame();
    for (int k = 0; k < 30 * IMG_W; k++) push_rect(k, 0, 10, 10, 10, 1'b0);
    begin_frame();
    for (int k = 0; k < 30 * IMG_W; k++) push_rect(k, 40, 20, 10, 10, k == 30 * IMG_W - 1);
    await_result("restart", 100, 1'b1, 44, 24, 46, 1'b0);

    // Overflow guard: pulses past the last line are ignored
    set_box(0, 1023, 0, 1023, 0, 1023);
    begin_frame();
    for (int k = 0; k < 16500; k++) push(0, 0, 0, k == 16499);
    await_result("overflow", 16384, 1'b1, 63, 63, 46, 1'b0);

    // Async reset while dividing x
    set_box(800, 1023, 0, 100, 0, 100);
    begin_frame();
    for (int k = 0; k < 10 * IMG_W; k++) push_rect(k, 40, 0, 10, 10, k == 10 * IMG_W - 1);
    repeat (10) cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_div:busy", o_busy, 0);
    check("rst_div:found", o_found, 0);
    check("rst_div:x", o_x, 0);
    check("rst_div:y", o_y, 0);
    check("rst_div:count", o_count, 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 60; k++) begin
        i_finish = (k % 7 == 0);
        i_valid  = 1'b1;
        @(negedge clk);
        if (o_valid || o_busy) stray++;
        cyc();
      end
      i_finish = 1'b0; i_valid = 1'b0;
      check("rst_div:idle_after_reset", stray, 0);
    end
    exp_x = 0; exp_y = 0;
    begin_frame();
    for (int k = 0; k < 10 * IMG_W; k++) push_rect(k, 40, 0, 10, 10, k == 10 * IMG_W - 1);
    await_result("after_reset", 100, 1'b1, 44, 4, 46, 1'b0);
    exp_x = 44; exp_y = 4;

    // Randomized frames against the model, with gaps and ignored inputs during the divide
    for (int f = 0; f < 6; f++) begin
      int rl, gl, bl, rh, gh, bh, pct, n;
      bit e_found;
      rl = $urandom_range(0, 700); rh = rl + $urandom_range(0, 300);
      gl = $urandom_range(0, 700); gh = gl + $urandom_range(0, 300);
      bl = $urandom_range(0, 700); bh = bl + $urandom_range(0, 300);
      if (f == 2) gl = gh + 1;
      set_box(rl, rh, gl, gh, bl, bh);
      pct = $urandom_range(3, 60);
      n   = $urandom_range(200, 1200);
      begin_frame();
      @(negedge clk);
      check($sformatf("rand%0d:busy_accum", f), o_busy, 1);
      cyc();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) cyc();
        if ($urandom_range(0, 99) < pct)
          push($urandom_range(rh, rl), $urandom_range(gh, gl), $urandom_range(bh, bl), 1'b0);
        else
          push($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
      end
      i_finish = 1'b1;
      cyc();
      i_finish = 1'b0;
      e_found = (m_cnt >= MIN_COUNT);
      if (e_found) begin
        exp_x = int'(m_sx / longint'(m_cnt));
        exp_y = int'(m_sy / longint'(m_cnt));
      end
      await_result($sformatf("rand%0d", f), m_cnt, e_found, exp_x, exp_y, e_found ? 46 : 2, e_found);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
